// File: rtl/lattuino_rst_ctrl.sv
// Reset sequencer for the Lattuino_1 system: merges PLL lock, reset pin, button and DTR edge,
// stretches the reset and latches its cause. Optional DTR path: define LATTUINO_RST_DTR_EN.
module lattuino_rst_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned BTN_HOLD    = 24000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ext_rst_n_i,
  input  logic       pll_lock_i,
  input  logic       dtr_i,
  input  logic       btn_i,
  output logic       rst_o,
  output logic [3:0] cause_o
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned BtnW = $clog2(BTN_HOLD + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [BtnW-1:0] BtnMax  = BtnW'(BTN_HOLD);
  localparam logic [BtnW-1:0] BtnFire = BtnW'(BTN_HOLD - 1);

  localparam logic [1:0] StWaitLock = 2'd0;
  localparam logic [1:0] StHold     = 2'd1;
  localparam logic [1:0] StRun      = 2'd2;

  logic [SYNC_STAGES-1:0] ext_sync_q, lock_sync_q;
  logic                   ext_s, lock_s, t_dtr;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ext_sync_q  <= '1;
      lock_sync_q <= '0;
    end else begin
      ext_sync_q  <= {ext_sync_q[SYNC_STAGES-2:0], ext_rst_n_i};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  assign ext_s  = ext_sync_q[SYNC_STAGES-1];
  assign lock_s = lock_sync_q[SYNC_STAGES-1];

`ifdef LATTUINO_RST_DTR_EN
  logic [SYNC_STAGES-1:0] dtr_sync_q;
  logic                   dtr_dly_q;

  // Preset to idle-high so leaving reset never looks like a falling edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      dtr_sync_q <= '1;
      dtr_dly_q  <= 1'b1;
    end else begin
      dtr_sync_q <= {dtr_sync_q[SYNC_STAGES-2:0], dtr_i};
      dtr_dly_q  <= dtr_sync_q[SYNC_STAGES-1];
    end
  end

  assign t_dtr = dtr_dly_q & ~dtr_sync_q[SYNC_STAGES-1];
`else
  logic unused_dtr;
  assign unused_dtr = dtr_i;
  assign t_dtr      = 1'b0;
`endif

  logic [BtnW-1:0] btn_cnt_q, btn_cnt_d;
  logic            btn_pulse_q, btn_pulse_d;

  // Counter saturates at BTN_HOLD, so the pulse fires once per press.
  always_comb begin
    btn_cnt_d = btn_cnt_q;
    if (!btn_i) begin
      btn_cnt_d = '0;
    end else if (btn_cnt_q != BtnMax) begin
      btn_cnt_d = btn_cnt_q + BtnW'(1);
    end
    btn_pulse_d = btn_i && (btn_cnt_q == BtnFire);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      btn_cnt_q   <= '0;
      btn_pulse_q <= 1'b0;
    end else begin
      btn_cnt_q   <= btn_cnt_d;
      btn_pulse_q <= btn_pulse_d;
    end
  end

  logic [3:0]      trig;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      cause_q, cause_d;
  logic            rst_q, rst_d;

  assign trig = {t_dtr, btn_pulse_q, ~ext_s, 1'b0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      StWaitLock: begin
        if (lock_s) begin
          state_d = StHold;
          cnt_d   = CntLoad;
        end
      end
      StHold: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cause_d = cause_q | 4'b0001;
        end else if (|trig) begin
          cnt_d   = CntLoad;
          cause_d = cause_q | trig;
        end else begin
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) state_d = StRun;
        end
      end
      StRun: begin
        // Entry to reset replaces the cause rather than accumulating it.
        if (!lock_s) begin
          state_d = StWaitLock;
          cause_d = 4'b0001;
        end else if (|trig) begin
          state_d = StHold;
          cnt_d   = CntLoad;
          cause_d = trig;
        end
      end
      default: state_d = StWaitLock;
    endcase
    rst_d = (state_d != StRun);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      cause_q <= 4'b0001;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      rst_q   <= rst_d;
    end
  end

  assign rst_o   = rst_q;
  assign cause_o = cause_q;

endmodule

// File: tb/tb_lattuino_rst_ctrl.sv
// Bench for lattuino_rst_ctrl: directed vector table, latency sequence, and random traffic
// checked against an age-based reference model.
module tb_lattuino_rst_ctrl;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned HoldCycles = 16;
  localparam int unsigned BtnHold    = 8;
`ifdef LATTUINO_RST_DTR_EN
  localparam bit DtrEn = 1'b1;
`else
  localparam bit DtrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, ext_n, lock, dtr, btn;
  logic       rst_o;
  logic [3:0] cause_o;

  int errors = 0;
  int checks = 0;

  lattuino_rst_ctrl #(
    .SYNC_STAGES(SyncStages),
    .HOLD_CYCLES(HoldCycles),
    .BTN_HOLD   (BtnHold)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .ext_rst_n_i(ext_n),
    .pll_lock_i (lock),
    .dtr_i      (dtr),
    .btn_i      (btn),
    .rst_o      (rst_o),
    .cause_o    (cause_o)
  );

  always #5 clk = ~clk;

  // Reference model: synchronisers as delay queues, reset length as age since last event.
  bit         ext_hist[$], lock_hist[$], dtr_hist[$];
  bit         m_prev_dtr, m_wait;
  int         m_run, m_age;
  logic       m_rst;
  logic [3:0] m_cause;

  task automatic model_step();
    bit ext_s, lock_s, dtr_s, t_ext, t_dtr, t_btn, running;
    logic [3:0] trg;
    if (!rst_n) begin
      ext_hist = {}; lock_hist = {}; dtr_hist = {};
      for (int i = 0; i < SyncStages; i++) begin
        ext_hist.push_back(1'b1);
        lock_hist.push_back(1'b0);
        dtr_hist.push_back(1'b1);
      end
      m_prev_dtr = 1'b1; m_run = 0; m_wait = 1'b1; m_age = 0;
      m_rst = 1'b1; m_cause = 4'b0001;
      return;
    end
    ext_s  = ext_hist.pop_front();  ext_hist.push_back(ext_n);
    lock_s = lock_hist.pop_front(); lock_hist.push_back(lock);
    dtr_s  = dtr_hist.pop_front();  dtr_hist.push_back(dtr);
    t_ext  = !ext_s;
    t_dtr  = DtrEn && m_prev_dtr && !dtr_s;
    m_prev_dtr = dtr_s;
    t_btn  = (m_run == BtnHold);
    m_run  = btn ? ((m_run < 1000000) ? m_run + 1 : m_run) : 0;
    trg    = {t_dtr, t_btn, t_ext, 1'b0};
    running = !m_rst;
    if (!lock_s) begin
      m_cause = running ? 4'b0001 : (m_cause | 4'b0001);
      m_wait  = 1'b1;
      m_rst   = 1'b1;
    end else if (m_wait) begin
      m_wait = 1'b0;
      m_age  = 0;
      m_rst  = 1'b1;
    end else if (trg != 4'b0000) begin
      m_cause = running ? trg : (m_cause | trg);
      m_age   = 0;
      m_rst   = 1'b1;
    end else if (!running) begin
      m_age++;
      if (m_age >= HoldCycles) m_rst = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic       rst_n, ext_n, lock, dtr, btn;
    int         n;
    logic       exp_rst;
    logic [3:0] exp_cause;
  } vec_t;

  vec_t vecs[$];

  task automatic add(logic r, logic e, logic l, logic d, logic b, int n, logic xr, logic [3:0] xc);
    vec_t v;
    v.rst_n = r; v.ext_n = e; v.lock = l; v.dtr = d; v.btn = b;
    v.n = n; v.exp_rst = xr; v.exp_cause = xc;
    vecs.push_back(v);
  endtask

  initial begin
    int lat, hold;
    rst_n = 1'b0; ext_n = 1'b1; lock = 1'b0; dtr = 1'b1; btn = 1'b0;

    //   rst_n ext lock dtr btn  n  rst cause
    add(0, 1, 0, 1, 0,  3, 1, 4'b0001);   // power-up
    add(1, 1, 0, 1, 0,  6, 1, 4'b0001);
    add(1, 1, 1, 1, 0, 18, 1, 4'b0001);   // lock rises
    add(1, 1, 1, 1, 0,  1, 0, 4'b0001);
    add(1, 1, 1, 1, 0,  5, 0, 4'b0001);
    add(1, 0, 1, 1, 0,  2, 0, 4'b0001);   // ext pin low 5 cycles
    add(1, 0, 1, 1, 0,  1, 1, 4'b0010);
    add(1, 0, 1, 1, 0,  2, 1, 4'b0010);
    add(1, 1, 1, 1, 0, 17, 1, 4'b0010);
    add(1, 1, 1, 1, 0,  1, 0, 4'b0010);
    add(1, 1, 1, 1, 1,  7, 0, 4'b0010);   // short press
    add(1, 1, 1, 1, 0,  3, 0, 4'b0010);
    add(1, 1, 1, 1, 1,  8, 0, 4'b0010);   // long press
    add(1, 1, 1, 1, 1,  1, 1, 4'b0100);
    add(1, 1, 1, 1, 1, 31, 0, 4'b0100);
    add(1, 1, 1, 1, 0,  3, 0, 4'b0100);
    add(1, 0, 1, 1, 0,  3, 1, 4'b0010);
    add(1, 1, 1, 1, 0, 13, 1, 4'b0010);   // now mid-HOLD, cnt=5
    add(0, 1, 1, 1, 0,  1, 1, 4'b0001);
    add(1, 1, 1, 1, 0, 18, 1, 4'b0001);
    add(1, 1, 1, 1, 0,  1, 0, 4'b0001);
    add(1, 1, 0, 1, 0,  2, 0, 4'b0001);   // lock loss in RUN
    add(1, 1, 0, 1, 0,  1, 1, 4'b0001);
    add(1, 1, 1, 1, 0, 18, 1, 4'b0001);
    add(1, 1, 1, 1, 0,  1, 0, 4'b0001);
`ifdef LATTUINO_RST_DTR_EN
    add(1, 1, 1, 0, 0,  2, 0, 4'b0001);   // DTR falling edge
    add(1, 1, 1, 0, 0,  1, 1, 4'b1000);
    add(1, 1, 1, 0, 0, 15, 1, 4'b1000);
    add(1, 1, 1, 0, 0,  1, 0, 4'b1000);
    add(1, 1, 1, 1, 0,  5, 0, 4'b1000);
`else
    add(1, 1, 1, 0, 0, 20, 0, 4'b0001);   // DTR ignored
    add(1, 1, 1, 1, 0,  5, 0, 4'b0001);
`endif
    add(1, 0, 1, 0, 0,  3, 1, DtrEn ? 4'b1010 : 4'b0010);
    add(1, 1, 0, 0, 0,  3, 1, DtrEn ? 4'b1011 : 4'b0011);
    add(1, 1, 1, 1, 0, 18, 1, DtrEn ? 4'b1011 : 4'b0011);
    add(1, 1, 1, 1, 0,  1, 0, DtrEn ? 4'b1011 : 4'b0011);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; ext_n = vecs[i].ext_n; lock = vecs[i].lock;
      dtr = vecs[i].dtr; btn = vecs[i].btn;
      repeat (vecs[i].n) tick();
      check($sformatf("vec%0d rst_o", i), int'(rst_o), int'(vecs[i].exp_rst));
      check($sformatf("vec%0d cause_o", i), int'(cause_o), int'(vecs[i].exp_cause));
    end

    // One-cycle pin pulse: rise latency and stretch length.
    ext_n = 1'b0;
    tick();
    ext_n = 1'b1;
    lat = 1;
    while (rst_o == 1'b0 && lat < 10) begin
      tick();
      lat++;
    end
    check("pulse rise latency", lat, SyncStages + 1);
    hold = 0;
    while (rst_o == 1'b1 && hold < 40) begin
      tick();
      hold++;
    end
    check("pulse hold length", hold, HoldCycles);
    check("pulse cause", int'(cause_o), 4'b0010);

    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 999) < 2) ? 1'b0 : 1'b1;
      ext_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      lock  = ($urandom_range(0, 999) < 4) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 99) < 3) dtr = ~dtr;
      btn   = btn ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 4);
      tick();
      check($sformatf("rand%0d rst_o", c), int'(rst_o), int'(m_rst));
      check($sformatf("rand%0d cause_o", c), int'(cause_o), int'(m_cause));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
